// File: rtl/filter_decim.sv
// filter_decim: sums blocks of DECIM valid samples, scales the sum by an arithmetic
// right shift, saturates it to WIDTH bits and queues the result in a DEPTH-entry FIFO
// with a valid/ready output.
// Optional feature: define FILTER_DECIM_ROUND_EN for round-half-up scaling; otherwise the
// shift truncates toward minus infinity.
module filter_decim #(
    parameter int WIDTH = 11,
    parameter int DECIM = 4,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             sat
);
    localparam int PW = $clog2(DECIM);
    localparam int AW = WIDTH + PW;
    // One spare bit above the accumulator so the rounding add cannot wrap
    localparam int SW = AW + 1;
    localparam int FW = $clog2(DEPTH);
    localparam int CW = FW + 1;

    localparam logic [PW-1:0] LastPhase = PW'(DECIM - 1);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic signed [SW-1:0] SatMax = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SatMin = ~SatMax;

`ifdef FILTER_DECIM_ROUND_EN
    // Half an output LSB; zero when no shift is applied
    localparam logic signed [SW-1:0] RoundTerm =
        SW'(((SHIFT > 0) ? 1 : 0) << ((SHIFT > 0) ? SHIFT - 1 : 0));
`endif

    // Block accumulation state
    logic [PW-1:0]        phase_q, phase_d;
    logic signed [AW-1:0] acc_q, acc_d;

    // FIFO state
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [FW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    // Sticky flags
    logic                 overflow_q, overflow_d;
    logic                 sat_q, sat_d;

    // Datapath intermediates
    logic signed [AW-1:0] in_ext;
    logic signed [AW-1:0] block_sum;
    logic signed [SW-1:0] sum_wide;
    logic signed [SW-1:0] rounded;
    logic signed [SW-1:0] scaled;
    logic                 clip_hi;
    logic                 clip_lo;
    logic [WIDTH-1:0]     result;
    logic                 block_done;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;

    assign in_ext     = {{PW{in[WIDTH-1]}}, in};
    assign block_done = in_valid && (phase_q == LastPhase);
    assign fifo_full  = (count_q == FullCount);
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    // A full FIFO still accepts the new result when the head leaves on the same edge
    assign push_ok    = block_done && (!fifo_full || pop);
    assign out        = mem_q[rd_ptr_q];
    assign overflow   = overflow_q;
    assign sat        = sat_q;

    // Block sum, scaling and saturation of the result being completed this cycle
    always_comb begin
        block_sum = acc_q + in_ext;
        sum_wide  = {block_sum[AW-1], block_sum};
`ifdef FILTER_DECIM_ROUND_EN
        rounded   = sum_wide + RoundTerm;
`else
        rounded   = sum_wide;
`endif
        scaled    = rounded >>> SHIFT;
        clip_hi   = (scaled > SatMax);
        clip_lo   = (scaled < SatMin);
        if (clip_hi) begin
            result = SatMax[WIDTH-1:0];
        end else if (clip_lo) begin
            result = SatMin[WIDTH-1:0];
        end else begin
            result = scaled[WIDTH-1:0];
        end
    end

    // Phase counter and accumulator next state; gaps in in_valid hold the block
    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        if (in_valid) begin
            if (phase_q == LastPhase) begin
                phase_d = '0;
                acc_d   = '0;
            end else if (phase_q == '0) begin
                phase_d = phase_q + PW'(1);
                acc_d   = in_ext;
            end else begin
                phase_d = phase_q + PW'(1);
                acc_d   = acc_q + in_ext;
            end
        end
    end

    // FIFO pointers, storage, occupancy and sticky flags next state
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sat_d      = sat_q;

        if (block_done && (clip_hi || clip_lo)) begin
            sat_d = 1'b1;
        end
        if (block_done && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + FW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            acc_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_filter_decim.sv
// Bench for filter_decim: two instances (default SHIFT and SHIFT=0) share one stimulus
// stream; a block-level model predicts each FIFO's contents and flags every cycle.
module tb_filter_decim;
    localparam int DECIM = 4;
    localparam int DEPTH = 4;

`ifdef FILTER_DECIM_ROUND_EN
    localparam int Round111 = 1;
`else
    localparam int Round111 = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] in_s = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [10:0] out_a, out_b;
    logic        out_valid_a, out_valid_b;
    logic        ov_a, ov_b, sat_a, sat_b;

    int total = 0;
    int bad = 0;

    filter_decim #(.WIDTH(11), .DECIM(4), .SHIFT(2), .DEPTH(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .in_valid (in_valid),
        .out      (out_a),
        .out_valid(out_valid_a),
        .out_ready(out_ready),
        .overflow (ov_a),
        .sat      (sat_a)
    );

    filter_decim #(.WIDTH(11), .DECIM(4), .SHIFT(0), .DEPTH(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .in_valid (in_valid),
        .out      (out_b),
        .out_valid(out_valid_b),
        .out_ready(out_ready),
        .overflow (ov_b),
        .sat      (sat_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int blk[$];
    int qa[$];
    int qb[$];
    bit m_sat_a, m_sat_b, m_ov_a, m_ov_b;
    bit model_live = 1'b0;
    bit pa, pb, done, ca, cb;
    int ra, rb, bsum;

    // floor(sum / 2^sh), optionally with half-up rounding, then clip to 11-bit signed
    function automatic int scale(input int s, input int sh, output bit clip);
        int d = 1 << sh;
        int n = s;
        int y;
`ifdef FILTER_DECIM_ROUND_EN
        if (sh > 0) n = s + d / 2;
`endif
        y = n / d;
        if ((n % d != 0) && (n < 0)) y = y - 1;
        clip = 1'b0;
        if (y > 1023) begin
            y = 1023;
            clip = 1'b1;
        end else if (y < -1024) begin
            y = -1024;
            clip = 1'b1;
        end
        return y;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            blk.delete();
            qa.delete();
            qb.delete();
            m_sat_a = 0; m_sat_b = 0; m_ov_a = 0; m_ov_b = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            pa = (qa.size() > 0) && out_ready;
            pb = (qb.size() > 0) && out_ready;
            done = 1'b0;
            if (in_valid) begin
                blk.push_back(int'($signed(in_s)));
                if (blk.size() == DECIM) begin
                    bsum = 0;
                    foreach (blk[i]) bsum += blk[i];
                    ra = scale(bsum, 2, ca);
                    rb = scale(bsum, 0, cb);
                    done = 1'b1;
                    blk.delete();
                end
            end
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (done) begin
                if (ca) m_sat_a = 1;
                if (cb) m_sat_b = 1;
                if (qa.size() < DEPTH) qa.push_back(ra); else m_ov_a = 1;
                if (qb.size() < DEPTH) qb.push_back(rb); else m_ov_b = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            chk("a_valid", int'(out_valid_a), int'(qa.size() > 0));
            chk("b_valid", int'(out_valid_b), int'(qb.size() > 0));
            if (qa.size() > 0) chk("a_out", int'($signed(out_a)), qa[0]);
            if (qb.size() > 0) chk("b_out", int'($signed(out_b)), qb[0]);
            chk("a_sat", int'(sat_a), int'(m_sat_a));
            chk("b_sat", int'(sat_b), int'(m_sat_b));
            chk("a_ovf", int'(ov_a), int'(m_ov_a));
            chk("b_ovf", int'(ov_b), int'(m_ov_b));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input int v, input bit vld, input bit rdy);
        in_s = 11'(v);
        in_valid = vld;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic int head_a();
        return (qa.size() > 0) ? qa[0] : -99999;
    endfunction

    initial begin
        int n;
        int exp_drain[4];

        // Reset state
        reset = 1'b1;
        repeat (4) drive(0, 0, 1);
        reset = 1'b0;
        chk("rst_valid", int'(out_valid_a), 0);
        chk("rst_out", int'(out_a), 0);
        chk("rst_flags", int'({ov_a, sat_a, ov_b, sat_b}), 0);

        // Constant input, 1-cycle latency
        for (int i = 1; i <= 8; i++) begin
            drive(100, 1, 1);
            if (i == 3) chk("const_lat_before", int'(out_valid_a), 0);
            if (i == 4 || i == 8) begin
                chk("const_valid", int'(out_valid_a), 1);
                chk("const_out", int'($signed(out_a)), 100);
                chk("const_model", head_a(), 100);
            end
            if (i == 5) chk("const_popped", int'(out_valid_a), 0);
        end
        chk("const_sat", int'(sat_a), 0);
        drive(0, 0, 1);

        // Rounding
        drive(1, 1, 1); drive(1, 1, 1); drive(1, 1, 1); drive(0, 1, 1);
        chk("round_111", int'($signed(out_a)), Round111);
        chk("round_111_model", head_a(), Round111);
        chk("round_111_s0", int'($signed(out_b)), 3);
        drive(-3, 1, 1); drive(0, 1, 1); drive(0, 1, 1); drive(0, 1, 1);
        chk("round_m3", int'($signed(out_a)), -1);
        chk("round_m3_s0", int'($signed(out_b)), -3);

        // Saturation
        drive(1023, 1, 1); drive(1023, 1, 1); drive(1023, 1, 1);
        chk("sat_before", int'(sat_b), 0);
        drive(1023, 1, 1);
        chk("sat_hi_s0", int'($signed(out_b)), 1023);
        chk("sat_hi_flag_s0", int'(sat_b), 1);
        chk("sat_hi_a", int'($signed(out_a)), 1023);
        repeat (4) drive(-1024, 1, 1);
        chk("sat_lo_s0", int'($signed(out_b)), -1024);
        chk("sat_lo_a", int'($signed(out_a)), -1024);
        repeat (4) drive(-1023, 1, 1);
        chk("nosat_m1023", int'($signed(out_a)), -1023);
        chk("nosat_flag", int'(sat_a), 0);
        drive(0, 0, 1);

        // Backpressure with overflow
        reset = 1'b1; drive(0, 0, 0); reset = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            repeat (4) drive(10 * b, 1, 0);
            if (b == 4) chk("bp_no_ovf_yet", int'(ov_a), 0);
        end
        chk("bp_ovf", int'(ov_a), 1);
        chk("bp_stable", int'($signed(out_a)), 10);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", int'(out_valid_a), 1);
            chk("bp_drain", int'($signed(out_a)), 10 * (i + 1));
            drive(0, 0, 1);
        end
        chk("bp_empty", int'(out_valid_a), 0);

        // Full FIFO with simultaneous pop
        reset = 1'b1; drive(0, 0, 0); reset = 1'b0;
        for (int b = 0; b < 4; b++) repeat (4) drive(8 + 4 * b, 1, 0);
        drive(24, 1, 0); drive(24, 1, 0); drive(24, 1, 0);
        drive(24, 1, 1);
        chk("fullpop_ovf", int'(ov_a), 0);
        exp_drain = '{12, 16, 20, 24};
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_a) begin
                if (n < 4) chk("fullpop_data", int'($signed(out_a)), exp_drain[n]);
                n++;
            end
            drive(0, 0, 1);
        end
        chk("fullpop_occupancy", n, 4);

        // Valid gaps
        for (int i = 1; i <= 8; i++) begin
            drive(7, (i % 2) == 1, 1);
            if (i == 6) chk("gap_before", int'(out_valid_a), 0);
            if (i == 7) begin
                chk("gap_valid", int'(out_valid_a), 1);
                chk("gap_out", int'($signed(out_a)), 7);
            end
        end

        // Reset mid-block; in_valid on the reset edge is ignored
        drive(9, 1, 1); drive(9, 1, 1);
        reset = 1'b1; drive(99, 1, 1); reset = 1'b0;
        repeat (4) drive(5, 1, 1);
        chk("midrst_out", int'($signed(out_a)), 5);
        chk("midrst_out_s0", int'($signed(out_b)), 20);
        chk("midrst_flags", int'({ov_a, sat_a, sat_b}), 0);
        drive(0, 0, 1);
        drive(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
